// File: rtl/mux_scan_reg_pkg.sv
// Shared types and helpers for the registered scan multiplexer.
// Imported by mux_scan_reg and rr_pick.
package mux_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int MAX_W    = 64;
  localparam int MAX_BITS = 4096;

  // Channels past the packed vector read as zero, which
  // gives out-of-range selects their all-zero data.
  function automatic logic [MAX_W-1:0] ch_slice(
    input logic [MAX_BITS-1:0] din,
    input int unsigned         c,
    input int unsigned         w
  );
    return MAX_W'(din >> (c * w));
  endfunction

endpackage

// File: rtl/mux_scan_reg_rr_pick.sv
// Wrap-around first-set search starting at ptr.
// Rotates the doubled mask, then priority-encodes from bit 0.
module rr_pick
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;

  always_comb begin
    rot   = N_CH'({mask, mask} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SEL_W+1)'(N_CH))
      idx = SEL_W'(sum - (SEL_W+1)'(N_CH));
    else
      idx = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-channel mux with direct/scan channel choice
// and a valid/ready output that holds while stalled.
module mux_scan_reg
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int W     = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              en,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [W-1:0]      dout,
  output logic [SEL_W-1:0]  out_ch
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [SEL_W-1:0] chan;
  logic [W-1:0]     data_nxt;
  logic             scan;
  logic             have_ch;
  logic             free;
  logic             stall;
  logic             load;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .mask  (ch_mask),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    scan     = (mode == MODE_SCAN);
    have_ch  = scan ? pick_found : 1'b1;
    chan     = scan ? pick_idx : sel;
    free     = !out_valid || out_ready;
    stall    = !free;
    load     = en && free && have_ch;
    data_nxt = W'(ch_slice(MAX_BITS'(din), 32'(chan), W));
    ptr_nxt  = '0;
    if (scan) begin
      ptr_nxt = ptr;
      if (load)
        ptr_nxt = (chan == SEL_W'(N_CH - 1)) ? '0
                                             : chan + SEL_W'(1);
    end
  end

  // Direct mode parks ptr at 0 unless a stall freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        dout      <= data_nxt;
        out_ch    <= chan;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (!stall)
        ptr <= ptr_nxt;
    end
  end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel multiplexer; successor to the fixed 8:1 single-bit combinational channel selector.
- Generalised in channel count and data width.
- Adds a direct/scan mode:
  - Direct: the channel comes from the `sel` input.
  - Scan: an internal pointer round-robins over channels enabled in `ch_mask`.
- Output side is a valid/ready handshake with stall holding.
- Sits between parallel sample sources and a serial consumer.

Parameters:
- N_CH, 8, number of input channels (2..64; non-power-of-2 allowed).
- W, 1, data width per channel.
- SEL_W, $clog2(N_CH), select/channel-index width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  N_CH*W  packed channel data; channel c occupies bits [c*W +: W].
- sel  input  SEL_W  channel select, used in direct mode.
- mode  input  1  0 = direct, 1 = scan.
- ch_mask  input  N_CH  per-channel enable; used in scan mode only.
- en  input  1  request a new sample this cycle.
- out_ready  input  1  consumer accepts dout this cycle.
- out_valid  output  1  dout/out_ch hold an unconsumed sample.
- dout  output  W  registered selected data.
- out_ch  output  SEL_W  channel index that produced dout.

Behaviour:
- Reset (rst=1 at a clk edge, overrides all else): out_valid=0, dout=0, out_ch=0, scan pointer ptr=0.
- Reset mid-transfer drops any pending sample; no partial state survives.
- Free slot: free = !out_valid || out_ready.
- Load condition: load = en && free && have_ch.
  - Direct mode: have_ch = 1.
  - Scan mode: have_ch = |ch_mask.
- Channel choice:
  - Direct mode: chan = sel.
  - Scan mode: chan = first c with ch_mask[c]=1, searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1.
- On load at edge: dout <= din[chan*W +: W]; out_ch <= chan; out_valid <= 1. Latency: one clk from en to out_valid.
- Scan mode, on load: ptr <= (chan == N_CH-1) ? 0 : chan+1.
- Direct mode: ptr held at 0, so every entry into scan starts its search at channel 0.
- Mode may change on any cycle; the current cycle's mode governs the load. A registered sample is unaffected by a mode change.
- No load, out_valid=1, out_ready=1: out_valid <= 0. dout and out_ch retain their last values.
- No load, out_valid=1, out_ready=0 (stall): dout, out_ch and out_valid held. Inputs are ignored and ptr does not move.
- Simultaneous consume + load (out_valid=1, out_ready=1, en=1): new sample replaces the old in the same edge and out_valid stays 1. Full throughput is one sample per cycle.
- Direct mode with sel >= N_CH (non-power-of-2 N_CH): dout loads all-zero, out_ch = sel, out_valid = 1.
- Scan mode with ch_mask == 0: no load. ptr unchanged. Normal drain rules apply.
- ch_mask may change any cycle; only the current value is used.
- dout is pure data: no combinational path from din or sel to any output.
- out_valid depends only on registers. out_ready must not combinationally drive out_valid.

Decomposition:
- Package mux_scan_pkg:
  - mode constants MODE_DIRECT=0, MODE_SCAN=1;
  - helper function ch_slice(din, c) for the W-bit extraction.
- Sub-module rr_pick #(N_CH):
  - inputs: mask, ptr;
  - outputs: found, idx;
  - wrap-around first-set search, implemented as a doubled-mask priority encode.
- Top level holds the registers, load/drain logic and mux.

Test Plan (N_CH=8, W=1 unless stated):
- Direct truth: mode=0, din=8'b1000_0000, sel=7, en=1, out_ready=1 → next cycle out_valid=1, dout=1, out_ch=7. Then sel=6 → dout=0, out_ch=6.
- Stall/hold: load ch 3 with out_ready=0, then change din, sel and en for 4 cycles → dout, out_ch=3 and out_valid=1 unchanged. Raise out_ready with en=0 → out_valid=0 next cycle.
- Scan wrap:
  - mode=1, ch_mask=8'b1001_0010, en=1, out_ready=1 → out_ch sequence 1,4,7,1,4,7.
  - Mask changed to 8'b0000_0001 mid-sequence → next out_ch=0.
- Empty mask: mode=1, ch_mask=0, en=1 for 5 cycles → out_valid=0 throughout, ptr unchanged. Restore mask=8'h04 → out_ch=2.
- Width/out-of-range: N_CH=5, W=4, din channel 4 = 4'hA, sel=4 → dout=4'hA. sel=6 → dout=4'h0, out_ch=6.
- Reset mid-scan: scanning, out_valid=1, out_ready=0, assert rst one cycle → out_valid=0, dout=0, out_ch=0. First scan load after reset → out_ch = lowest set bit of ch_mask.
